bus_ctl: RTL
============

# bus_ctl

Parametrised bus controller for the RISC5 system bus: decodes the CPU word address into NSLV slave strobes, multiplexes slave read data and acknowledges, and adds a bus watchdog. Unmapped accesses and slaves that never acknowledge are completed with an error acknowledge instead of hanging the CPU. The faulting access is recorded in two internal status registers and raises an interrupt. It replaces the hand-written strobe and ternary-chain logic in the top level.

## Interface

- NSLV, 8, number of slave channels (1..16)
- AW, 22, word-address width (byte address bits AW+1:2)
- BASE, 0, packed NSLV*AW: slave i base at bits [i*AW +: AW]
- MASK, 0, packed NSLV*AW: slave i compare mask at bits [i*AW +: AW]
- STAT_ADDR, 22'h3FFFE0, word address of the status register; the fault-address register is at STAT_ADDR+1
- TMO, 255, watchdog limit in cycles; 0 disables the watchdog
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- m_stb  in  1  CPU bus strobe, held until m_ack
- m_we  in  1  CPU write enable
- m_addr  in  AW  CPU word address
- m_dout  in  32  CPU write data
- m_din  out  32  read data to CPU
- m_ack  out  1  acknowledge to CPU
- m_err  out  1  error qualifier, valid with m_ack
- s_stb  out  NSLV  per-slave strobe
- s_dout  in  NSLV*32  slave read data, slave i at [i*32 +: 32]
- s_ack  in  NSLV  per-slave acknowledge
- err_irq  out  1  level interrupt, equals the status VALID bit

The design has one clock. Reset is synchronous and active-low.

## Operation

- Decode: slave i hits when (m_addr & MASK_i) == BASE_i. The lowest hitting index wins. An access at STAT_ADDR or STAT_ADDR+1 is internal and has priority over all slaves.
- s_stb[i] = m_stb & selected(i). It is combinational, so slave data and ack reach the CPU in the same cycle (zero added latency). m_din = s_dout of the selected slave.
- Unmapped access (m_stb high, no hit, not internal): m_ack = m_err = 1 in the next cycle. m_din = ERR_DATA (32'hDEADDEAD). Fault recorded with CAUSE = 0.
- Watchdog FSM, states IDLE / WAIT / ERR:
  - IDLE → WAIT on m_stb to a slave.
  - WAIT counts cycles while the selected s_ack is low. It returns to IDLE on s_ack. It moves to ERR when the count reaches TMO.
  - ERR lasts one cycle with m_ack = 1. If s_ack is also high in that cycle, the slave ack and data win: m_err = 0 and nothing is recorded. Otherwise m_err = 1, m_din = ERR_DATA, and a fault is recorded with CAUSE = 1.
  - ERR → IDLE.
- Status register (STAT_ADDR):
  - bit0 VALID, bit1 CAUSE, bit2 WE of the faulting access.
  - bits 15:8 COUNT: saturating fault count, stuck at 255.
  - All other bits read 0.
- Fault-address register (STAT_ADDR+1): faulting m_addr, zero-extended to 32 bits. A later fault overwrites VALID, CAUSE, WE and the address, and increments COUNT.
- Internal read or write: ack in the next cycle, m_err = 0.
  - Any write to STAT_ADDR clears VALID and COUNT; m_dout is ignored.
  - Writes to STAT_ADDR+1 are ignored.
- Reset: all outputs are 0 (m_din = 0, m_ack = 0, m_err = 0, s_stb = 0 while m_stb = 0, err_irq = 0). FSM goes to IDLE, the counter and all fault state are cleared. Reset during WAIT or ERR aborts the cycle without any ack.
- Changing m_addr while m_stb is held without ack is a protocol violation. The counter keeps running.

## Timing

- Slave access: m_ack in the same cycle as s_ack.
- Unmapped and internal accesses: exactly 1 cycle of latency, registered ack.
- Timeout: with m_stb first high in cycle 0 and no s_ack, m_ack/m_err fire in cycle TMO.
- Counter width is clog2(TMO+1) bits. It clears on every ack, so there is no wrap-around.
- After any ack, the next cycle starts a new transaction if m_stb is still high.
- m_ack is never high for two consecutive cycles for one transaction.
- Internal acks are pulses; the registered ack flag clears after one cycle even if m_stb stays high.

## Structure

- Package bus_ctl_pkg holds:
  - ERR_DATA.
  - Status bit indices: ST_VALID = 0, ST_CAUSE = 1, ST_WE = 2, ST_COUNT_LSB = 8.
  - Cause codes: CAUSE_UNMAPPED = 0, CAUSE_TIMEOUT = 1.
  - Watchdog state encoding.
- Sub-module bus_wdog contains the FSM plus counter. It takes stb, ack and tmo_en, and outputs a one-cycle tmo pulse.
- Decode, muxing and status registers stay in bus_ctl.

## Test plan

- Decode: NSLV = 4, slave 2 at BASE 22'h010000 with MASK 22'h3F0000. Access to 22'h010004 → s_stb = 4'b0100, and m_din = s_dout[2] with m_ack in the s_ack cycle.
- Overlap: slaves 1 and 3 both hit → only s_stb[1] is asserted.
- Unmapped read: ack and err one cycle later, m_din = 32'hDEADDEAD. Status then reads 32'h0000_0101, the fault address reads the access address, and err_irq = 1.
- Timeout with TMO = 8 and a silent slave: ack/err in cycle 8, status reads 32'h0000_0103 for a read.
  - Slave acks in cycle 7 → no error.
  - Slave acks in cycle 8 → slave data, m_err = 0, no fault recorded.
- Saturation: 300 unmapped accesses → COUNT = 255. Then a write to STAT_ADDR → status reads 0 and err_irq = 0.
- Reset mid-WAIT: deassert rst_n in cycle 4 of a hung access → no m_ack, status reads 0, and the next access decodes normally.

Source files
------------

// File: rtl/bus_ctl_pkg.sv
// Shared constants and types for the RISC5 bus controller and its watchdog.
package bus_ctl_pkg;

    localparam logic [31:0] ERR_DATA = 32'hDEADDEAD;

    localparam int ST_VALID     = 0;
    localparam int ST_CAUSE     = 1;
    localparam int ST_WE        = 2;
    localparam int ST_COUNT_LSB = 8;

    localparam logic CAUSE_UNMAPPED = 1'b0;
    localparam logic CAUSE_TIMEOUT  = 1'b1;

    typedef enum logic [1:0] {
        WD_IDLE = 2'd0,
        WD_WAIT = 2'd1,
        WD_ERR  = 2'd2
    } wd_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/bus_wdog.sv
// Bus watchdog: counts cycles of an unacknowledged slave access and
// emits a one-cycle tmo pulse in the cycle the count reaches TMO.
module bus_wdog
    import bus_ctl_pkg::*;
#(
    parameter int TMO = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stb_i,
    input  logic ack_i,
    input  logic tmo_en_i,
    output logic tmo_o
);

    localparam int            CW    = (TMO < 1) ? 1 : $clog2(TMO + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TMO);
    localparam logic [CW-1:0] ONE   = CW'(1);

    wd_state_e     state_q;
    logic [CW-1:0] cnt_q;

    // cnt_q holds the number of cycles already spent waiting, so the
    // transition into ERR lands exactly TMO cycles after the first strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= WD_IDLE;
            cnt_q   <= '0;
            tmo_o   <= 1'b0;
        end else begin
            tmo_o <= 1'b0;
            case (state_q)
                WD_IDLE: begin
                    if (stb_i && !ack_i && tmo_en_i) begin
                        if (LIMIT <= ONE) begin
                            state_q <= WD_ERR;
                            tmo_o   <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= WD_WAIT;
                            cnt_q   <= ONE;
                        end
                    end
                end
                WD_WAIT: begin
                    if (ack_i) begin
                        state_q <= WD_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q + ONE == LIMIT) begin
                        state_q <= WD_ERR;
                        tmo_o   <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                WD_ERR: begin
                    state_q <= WD_IDLE;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= WD_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/bus_ctl.sv
// RISC5 bus controller: address decode, slave read/ack mux, error completion
// of unmapped or hung accesses, and the fault status/address registers.
module bus_ctl
    import bus_ctl_pkg::*;
#(
    parameter int                NSLV      = 8,
    parameter int                AW        = 22,
    parameter logic [NSLV*AW-1:0] BASE     = '0,
    parameter logic [NSLV*AW-1:0] MASK     = '0,
    parameter logic [AW-1:0]     STAT_ADDR = AW'(22'h3FFFE0),
    parameter int                TMO       = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               m_stb,
    input  logic               m_we,
    input  logic [AW-1:0]      m_addr,
    input  logic [31:0]        m_dout,
    output logic [31:0]        m_din,
    output logic               m_ack,
    output logic               m_err,
    output logic [NSLV-1:0]    s_stb,
    input  logic [NSLV*32-1:0] s_dout,
    input  logic [NSLV-1:0]    s_ack,
    output logic               err_irq
);

    localparam int            IW        = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam logic [AW-1:0] FADR_ADDR = STAT_ADDR + AW'(1);

    logic [IW-1:0] sel_idx;
    logic          hit_any, internal, slv_hit, slv_sel;
    logic [31:0]   sel_dout;
    logic          sel_ack, slv_ack, tmo, tmo_fault, req_int;
    logic [31:0]   status_rd;

    logic          ack_q, ack_d, err_q, err_d;
    logic [31:0]   rd_q, rd_d;
    logic          valid_q, valid_d, cause_q, cause_d, we_q, we_d;
    logic [7:0]    count_q, count_d;
    logic [AW-1:0] faddr_q, faddr_d;

    logic          unused_dout;
    assign unused_dout = ^m_dout;

    // Scanning from the top down leaves the lowest hitting index selected.
    always_comb begin
        hit_any = 1'b0;
        sel_idx = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ((m_addr & MASK[i*AW +: AW]) == BASE[i*AW +: AW]) begin
                hit_any = 1'b1;
                sel_idx = IW'(i);
            end
        end
    end

    assign internal = (m_addr == STAT_ADDR) || (m_addr == FADR_ADDR);
    assign slv_hit  = hit_any && !internal;
    assign slv_sel  = m_stb && slv_hit;

    always_comb begin
        s_stb    = '0;
        sel_dout = '0;
        sel_ack  = 1'b0;
        for (int i = 0; i < NSLV; i++) begin
            if (IW'(i) == sel_idx) begin
                s_stb[i] = slv_sel;
                sel_dout = s_dout[i*32 +: 32];
                sel_ack  = s_ack[i];
            end
        end
    end

    assign slv_ack = slv_sel && sel_ack;

    bus_wdog #(.TMO(TMO)) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .stb_i    (slv_sel),
        .ack_i    (slv_ack),
        .tmo_en_i (TMO != 0),
        .tmo_o    (tmo)
    );

    // A slave ack arriving in the timeout cycle completes the access normally.
    assign tmo_fault = tmo && !slv_ack;
    assign req_int   = m_stb && !slv_hit && !ack_q;

    always_comb begin
        status_rd                          = '0;
        status_rd[ST_VALID]                = valid_q;
        status_rd[ST_CAUSE]                = cause_q;
        status_rd[ST_WE]                   = we_q;
        status_rd[ST_COUNT_LSB +: 8]       = count_q;
    end

    always_comb begin
        ack_d   = req_int;
        err_d   = req_int && !internal;
        rd_d    = rd_q;
        valid_d = valid_q;
        cause_d = cause_q;
        we_d    = we_q;
        count_d = count_q;
        faddr_d = faddr_q;
        if (req_int) begin
            if (!internal)
                rd_d = ERR_DATA;
            else if (m_addr == STAT_ADDR)
                rd_d = status_rd;
            else
                rd_d = 32'(faddr_q);
        end
        if (req_int && internal && m_we && (m_addr == STAT_ADDR)) begin
            valid_d = 1'b0;
            count_d = '0;
        end else if ((req_int && !internal) || tmo_fault) begin
            valid_d = 1'b1;
            cause_d = tmo_fault ? CAUSE_TIMEOUT : CAUSE_UNMAPPED;
            we_d    = m_we;
            faddr_d = m_addr;
            count_d = sat_inc8(count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            cause_q <= 1'b0;
            we_q    <= 1'b0;
            count_q <= '0;
            faddr_q <= '0;
        end else begin
            ack_q   <= ack_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            cause_q <= cause_d;
            we_q    <= we_d;
            count_q <= count_d;
            faddr_q <= faddr_d;
        end
    end

    always_ff @(posedge clk) begin
        rd_q <= rd_d;
    end

    // Outputs are gated by rst_n so a reset in WAIT/ERR never completes the access.
    assign m_ack   = rst_n && (ack_q || slv_ack || tmo);
    assign m_err   = rst_n && ((ack_q && err_q) || tmo_fault);
    assign m_din   = !rst_n    ? 32'h0 :
                     ack_q     ? rd_q :
                     tmo_fault ? ERR_DATA :
                     slv_sel   ? sel_dout : 32'h0;
    assign err_irq = valid_q;

endmodule
